spi_mpu_burst: RTL
==================

Name: spi_mpu_burst

Overview:
SPI master for the MPU IMU that runs a complete register transaction: one address byte, then either one write byte or a burst of 1..2^LEN_W-1 read bytes.
- Each read byte is streamed out with a valid pulse and a byte index, so a full sensor block (accel/temp/gyro) comes back in one chip-select window.
- Sits between the sensor-sequencing FSM and the MPU pins; drives sclk, cs_n and mosi, and samples miso.

Parameters:
CLK_DIV, 3, sclk half-period = 2**CLK_DIV clk cycles
HOLD_BITS, 4, cs_n setup time and hold time, each = 2**HOLD_BITS clk cycles
LEN_W, 4, width of len; maximum burst = 2**LEN_W-1 bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin transaction; sampled only in IDLE
rw  in  1  1 = read burst, 0 = single-byte write
addr  in  7  MPU register address
len  in  LEN_W  read byte count; 0 is treated as 1; ignored for writes
wdata  in  8  write byte
miso  in  1  serial data from MPU
sclk  out  1  SPI clock, mode 3 (idles high)
cs_n  out  1  chip select, active low
mosi  out  1  serial data to MPU
busy  out  1  high from the cycle after start is accepted until finish
finish  out  1  one-cycle done pulse
rx_data  out  8  last received byte; held between bytes
rx_valid  out  1  one-cycle pulse per received byte
rx_idx  out  LEN_W  index of the byte in rx_data, 0-based

Behaviour:
- Reset values: sclk=1, cs_n=1, mosi=0, busy=0, finish=0, rx_data=0, rx_valid=0, rx_idx=0, FSM=IDLE.
- Reset mid-transaction: on the next edge all outputs take reset values. No finish pulse and no rx_valid are generated.
- IDLE: on start=1, latch {rw,addr}, len (0 becomes 1), wdata, then go to SETUP. On the next cycle cs_n=0 and busy=1.
- start while busy is ignored. Latched values are not affected by input changes mid-transaction.
- SETUP: hold cs_n low and sclk high for 2**HOLD_BITS cycles, then go to SHIFT.
- SHIFT: shift MSB first.
  - First byte is {rw,addr[6:0]}, so bit 7 = 1 for a read.
  - Following bytes are wdata (write) or 0x00 (read).
  - Each bit: sclk falls and mosi updates on the same edge; sclk low for 2**CLK_DIV cycles.
  - Then sclk rises and miso is sampled on that edge; sclk high for 2**CLK_DIV cycles.
- Bytes shifted = 2 for a write, 1+len for a read.
- Read data bytes: after the 8th sampled bit, rx_data takes the byte on the next edge, with rx_valid=1 for one cycle and rx_idx = byte number. No rx_valid occurs for the address byte or for writes.
- After the last bit, sclk stays high and the FSM goes to HOLD.
- HOLD: 2**HOLD_BITS cycles with cs_n low, then DONE.
- DONE: cs_n=1, busy=0, finish=1 on the same edge, for one cycle; mosi=0; return to IDLE.
- A start asserted during the finish cycle is accepted.
- Timing: cs_n low duration = 2*2**HOLD_BITS + 16*2**CLK_DIV*(bytes shifted) cycles.
- Counters: bit counter 3 bits; byte counter LEN_W+1 bits, so len = 2**LEN_W-1 does not wrap.

Test Plan:
Configuration for all scenarios: CLK_DIV=1, HOLD_BITS=2, LEN_W=4.
1. Single read, rw=1 addr=0x37 len=1, miso slave returns 0xA5 -> mosi shows 0xB7 then 0x00; one rx_valid with rx_data=0xA5, rx_idx=0; cs_n low exactly 72 cycles; finish 1 cycle; busy drops with it.
2. Burst read, rw=1 addr=0x3B len=3, slave returns 0x12,0x34,0x56 -> three rx_valid pulses 32 cycles apart, data 0x12/0x34/0x56, idx 0/1/2; cs_n low 136 cycles.
3. Write, rw=0 addr=0x6B wdata=0x80 len=5 -> mosi shows 0x6B then 0x80; no rx_valid; cs_n low 72 cycles.
4. len=0 read -> identical to len=1. start pulsed mid-transfer -> ignored, no second cs_n window. start during the finish cycle -> new transaction, cs_n low again next cycle.
5. rst asserted during the 2nd data byte -> next edge cs_n=1, sclk=1, busy=0, no finish; a following read of 0x75 returns 0x71 correctly.
6. Waveform check -> sclk low 2 cycles and high 2 cycles per bit, mosi stable across each rising edge, sclk high throughout SETUP and HOLD.

Source files
------------

// File: rtl/spi_mpu_burst.sv
// SPI mode-3 master for the MPU IMU.
// Runs one register transaction inside a single chip-select window:
// an address byte, then either one write byte or a burst of read bytes.
// Each read byte is streamed out with a valid pulse and its index.
module spi_mpu_burst #(
  parameter int CLK_DIV   = 3,
  parameter int HOLD_BITS = 4,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             busy,
  output logic             finish,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [LEN_W-1:0] rx_idx
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // Within one bit period the divider runs 0..2*2**CLK_DIV-1; sclk rises
  // on the edge that leaves the last low cycle.
  localparam logic [CLK_DIV:0] RISE_AT = (CLK_DIV+1)'((1 << CLK_DIV) - 1);

  state_t state;
  state_t state_nx;

  logic                 rw_q;
  logic [7:0]           wdata_q;
  logic [LEN_W:0]       nbytes_q;
  logic [LEN_W:0]       req_bytes;
  logic [7:0]           tx_shift;
  logic [7:0]           rx_shift;
  logic [7:0]           next_byte;
  logic [CLK_DIV:0]     div_cnt;
  logic [2:0]           bit_cnt;
  logic [LEN_W:0]       byte_cnt;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic                 rx_pend;
  logic [LEN_W-1:0]     rx_pend_idx;
  logic                 hold_end;
  logic                 bit_end;
  logic                 bit_rise;
  logic                 last_bit;

  // Derived control terms shared by the next-state logic and the datapath.
  always_comb begin
    req_bytes = (LEN_W+1)'(2);
    if (rw) begin
      if (len == '0) begin
        req_bytes = (LEN_W+1)'(2);
      end else begin
        req_bytes = {1'b0, len} + (LEN_W+1)'(1);
      end
    end
    next_byte = rw_q ? 8'h00 : wdata_q;
    hold_end  = (hold_cnt == '1);
    bit_end   = (div_cnt == '1);
    bit_rise  = (div_cnt == RISE_AT);
    last_bit  = (bit_cnt == 3'd7) && (byte_cnt == (nbytes_q - (LEN_W+1)'(1)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (hold_end) state_nx = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_nx = HOLD;
      HOLD:    if (hold_end) state_nx = DONE;
      DONE:    state_nx = start ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Chip select, busy and finish decode directly from the registered state.
  always_comb begin
    cs_n   = 1'b1;
    busy   = 1'b0;
    finish = 1'b0;
    case (state)
      SETUP, SHIFT, HOLD: begin
        cs_n = 1'b0;
        busy = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latching the request, bit timing, shifting and read-byte delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      nbytes_q    <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      hold_cnt    <= '0;
      rx_pend     <= 1'b0;
      rx_pend_idx <= '0;
      sclk        <= 1'b1;
      mosi        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_idx      <= '0;
    end else begin
      rx_valid <= 1'b0;
      hold_cnt <= (state == SETUP || state == HOLD) ? hold_cnt + HOLD_BITS'(1) : '0;
      div_cnt  <= (state == SHIFT) ? div_cnt + (CLK_DIV+1)'(1) : '0;

      if (rx_pend) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        rx_idx   <= rx_pend_idx;
        rx_pend  <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          sclk <= 1'b1;
          mosi <= 1'b0;
          if (start) begin
            rw_q     <= rw;
            wdata_q  <= wdata;
            nbytes_q <= req_bytes;
            tx_shift <= {rw, addr};
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        SETUP: begin
          if (hold_end) begin
            sclk     <= 1'b0;
            mosi     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        SHIFT: begin
          if (bit_rise) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[6:0], miso};
            if (bit_cnt == 3'd7 && rw_q && byte_cnt != '0) begin
              rx_pend     <= 1'b1;
              rx_pend_idx <= LEN_W'(byte_cnt - (LEN_W+1)'(1));
            end
          end else if (bit_end && !last_bit) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + (LEN_W+1)'(1);
              mosi     <= next_byte[7];
              tx_shift <= {next_byte[6:0], 1'b0};
            end else begin
              mosi     <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (hold_end) begin
            mosi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
